// File: rtl/control_pipe_reg.sv
// Decode-to-execute control pipeline register with HI/LO divide hazard tracking.
// A divide counter tracks when HI/LO become valid; stall_d holds D while a HI/LO access must wait.
module control_pipe_reg #(
  parameter int unsigned ALU_OP_W    = 4,
  parameter int unsigned SHAMT_W     = 5,
  parameter int unsigned DIV_LATENCY = 32,
  localparam int unsigned CNT_W      = $clog2(DIV_LATENCY + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                stall_e,
  input  logic                flush_e,
  input  logic                valid_d,
  input  logic                reg_write_d,
  input  logic                mem_to_reg_d,
  input  logic                mem_write_d,
  input  logic                alu_src_d,
  input  logic                reg_dest_d,
  input  logic                syscall_d,
  input  logic                is_byte_d,
  input  logic                link_reg_d,
  input  logic [ALU_OP_W-1:0] alu_op_d,
  input  logic [SHAMT_W-1:0]  shamt_d,
  input  logic                is_mf_hi_d,
  input  logic                is_mf_lo_d,
  input  logic                has_div_d,
  output logic                valid_e,
  output logic                reg_write_e,
  output logic                mem_to_reg_e,
  output logic                mem_write_e,
  output logic                alu_src_e,
  output logic                reg_dest_e,
  output logic                syscall_e,
  output logic                is_byte_e,
  output logic                link_reg_e,
  output logic [ALU_OP_W-1:0] alu_op_e,
  output logic [SHAMT_W-1:0]  shamt_e,
  output logic                is_mf_hi_e,
  output logic                is_mf_lo_e,
  output logic                has_div_e,
  output logic                stall_d,
  output logic                div_busy,
  output logic                div_done
);

  if (DIV_LATENCY < 1) begin : gen_bad_latency
    $error("control_pipe_reg: DIV_LATENCY must be at least 1");
  end

  typedef struct packed {
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_write;
    logic                alu_src;
    logic                reg_dest;
    logic                syscall;
    logic                is_byte;
    logic                link_reg;
    logic [ALU_OP_W-1:0] alu_op;
    logic [SHAMT_W-1:0]  shamt;
    logic                is_mf_hi;
    logic                is_mf_lo;
    logic                has_div;
  } ctrl_t;

  ctrl_t            ctrl_d_bundle;
  ctrl_t            ctrl_e_d, ctrl_e_q;
  logic             valid_e_d, valid_e_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             div_done_d, div_done_q;
  logic             hilo_hazard;
  logic             capture;
  logic             issue;

  always_comb begin
    ctrl_d_bundle            = '0;
    ctrl_d_bundle.reg_write  = reg_write_d;
    ctrl_d_bundle.mem_to_reg = mem_to_reg_d;
    ctrl_d_bundle.mem_write  = mem_write_d;
    ctrl_d_bundle.alu_src    = alu_src_d;
    ctrl_d_bundle.reg_dest   = reg_dest_d;
    ctrl_d_bundle.syscall    = syscall_d;
    ctrl_d_bundle.is_byte    = is_byte_d;
    ctrl_d_bundle.link_reg   = link_reg_d;
    ctrl_d_bundle.alu_op     = alu_op_d;
    ctrl_d_bundle.shamt      = shamt_d;
    ctrl_d_bundle.is_mf_hi   = is_mf_hi_d;
    ctrl_d_bundle.is_mf_lo   = is_mf_lo_d;
    ctrl_d_bundle.has_div    = has_div_d;
  end

  assign div_busy    = (cnt_q != '0);
  assign hilo_hazard = valid_d & div_busy & (is_mf_hi_d | is_mf_lo_d | has_div_d);
  assign stall_d     = hilo_hazard | stall_e;

  // Only a D-stage instruction that actually lands in E may start the divider.
  assign capture = ~flush_e & ~stall_e & valid_d & ~hilo_hazard;
  assign issue   = capture & has_div_d;

  always_comb begin
    ctrl_e_d  = ctrl_e_q;
    valid_e_d = valid_e_q;
    if (flush_e) begin
      ctrl_e_d  = '0;
      valid_e_d = 1'b0;
    end else if (stall_e) begin
      ctrl_e_d  = ctrl_e_q;
      valid_e_d = valid_e_q;
    end else if (capture) begin
      ctrl_e_d  = ctrl_d_bundle;
      valid_e_d = 1'b1;
    end else begin
      ctrl_e_d  = '0;
      valid_e_d = 1'b0;
    end
  end

  // The divider runs on its own, so the count ignores stall_e and flush_e.
  always_comb begin
    cnt_d = cnt_q;
    if (issue) begin
      cnt_d = CNT_W'(DIV_LATENCY);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    div_done_d = (cnt_q == CNT_W'(1)) & ~issue;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctrl_e_q   <= '0;
      valid_e_q  <= 1'b0;
      cnt_q      <= '0;
      div_done_q <= 1'b0;
    end else begin
      ctrl_e_q   <= ctrl_e_d;
      valid_e_q  <= valid_e_d;
      cnt_q      <= cnt_d;
      div_done_q <= div_done_d;
    end
  end

  assign valid_e      = valid_e_q;
  assign reg_write_e  = ctrl_e_q.reg_write;
  assign mem_to_reg_e = ctrl_e_q.mem_to_reg;
  assign mem_write_e  = ctrl_e_q.mem_write;
  assign alu_src_e    = ctrl_e_q.alu_src;
  assign reg_dest_e   = ctrl_e_q.reg_dest;
  assign syscall_e    = ctrl_e_q.syscall;
  assign is_byte_e    = ctrl_e_q.is_byte;
  assign link_reg_e   = ctrl_e_q.link_reg;
  assign alu_op_e     = ctrl_e_q.alu_op;
  assign shamt_e      = ctrl_e_q.shamt;
  assign is_mf_hi_e   = ctrl_e_q.is_mf_hi;
  assign is_mf_lo_e   = ctrl_e_q.is_mf_lo;
  assign has_div_e    = ctrl_e_q.has_div;
  assign div_done     = div_done_q;

endmodule

// File: tb/tb_control_pipe_reg.sv
// Directed bench for control_pipe_reg: instance a uses DIV_LATENCY=4, instance b uses 8.
// Both share the same stimulus; each scenario checks the instance it targets.
module tb_control_pipe_reg;

  logic       clock = 1'b0;
  logic       reset_n, stall_e, flush_e, valid_d;
  logic       reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d;
  logic       reg_dest_d, syscall_d, is_byte_d, link_reg_d;
  logic [3:0] alu_op_d;
  logic [4:0] shamt_d;
  logic       is_mf_hi_d, is_mf_lo_d, has_div_d;

  logic       a_valid_e, a_reg_write_e, a_mem_to_reg_e, a_mem_write_e, a_alu_src_e;
  logic       a_reg_dest_e, a_syscall_e, a_is_byte_e, a_link_reg_e;
  logic [3:0] a_alu_op_e;
  logic [4:0] a_shamt_e;
  logic       a_is_mf_hi_e, a_is_mf_lo_e, a_has_div_e, a_stall_d, a_div_busy, a_div_done;

  logic       b_valid_e, b_reg_write_e, b_mem_to_reg_e, b_mem_write_e, b_alu_src_e;
  logic       b_reg_dest_e, b_syscall_e, b_is_byte_e, b_link_reg_e;
  logic [3:0] b_alu_op_e;
  logic [4:0] b_shamt_e;
  logic       b_is_mf_hi_e, b_is_mf_lo_e, b_has_div_e, b_stall_d, b_div_busy, b_div_done;

  logic [22:0] a_all, b_all;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign a_all = {a_valid_e, a_reg_write_e, a_mem_to_reg_e, a_mem_write_e, a_alu_src_e,
                  a_reg_dest_e, a_syscall_e, a_is_byte_e, a_link_reg_e, a_alu_op_e, a_shamt_e,
                  a_is_mf_hi_e, a_is_mf_lo_e, a_has_div_e, a_div_busy, a_div_done};
  assign b_all = {b_valid_e, b_reg_write_e, b_mem_to_reg_e, b_mem_write_e, b_alu_src_e,
                  b_reg_dest_e, b_syscall_e, b_is_byte_e, b_link_reg_e, b_alu_op_e, b_shamt_e,
                  b_is_mf_hi_e, b_is_mf_lo_e, b_has_div_e, b_div_busy, b_div_done};

  control_pipe_reg #(.ALU_OP_W(4), .SHAMT_W(5), .DIV_LATENCY(4)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d),
    .mem_write_d(mem_write_d), .alu_src_d(alu_src_d), .reg_dest_d(reg_dest_d),
    .syscall_d(syscall_d), .is_byte_d(is_byte_d), .link_reg_d(link_reg_d),
    .alu_op_d(alu_op_d), .shamt_d(shamt_d), .is_mf_hi_d(is_mf_hi_d),
    .is_mf_lo_d(is_mf_lo_d), .has_div_d(has_div_d),
    .valid_e(a_valid_e), .reg_write_e(a_reg_write_e), .mem_to_reg_e(a_mem_to_reg_e),
    .mem_write_e(a_mem_write_e), .alu_src_e(a_alu_src_e), .reg_dest_e(a_reg_dest_e),
    .syscall_e(a_syscall_e), .is_byte_e(a_is_byte_e), .link_reg_e(a_link_reg_e),
    .alu_op_e(a_alu_op_e), .shamt_e(a_shamt_e), .is_mf_hi_e(a_is_mf_hi_e),
    .is_mf_lo_e(a_is_mf_lo_e), .has_div_e(a_has_div_e), .stall_d(a_stall_d),
    .div_busy(a_div_busy), .div_done(a_div_done)
  );

  control_pipe_reg #(.ALU_OP_W(4), .SHAMT_W(5), .DIV_LATENCY(8)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d),
    .mem_write_d(mem_write_d), .alu_src_d(alu_src_d), .reg_dest_d(reg_dest_d),
    .syscall_d(syscall_d), .is_byte_d(is_byte_d), .link_reg_d(link_reg_d),
    .alu_op_d(alu_op_d), .shamt_d(shamt_d), .is_mf_hi_d(is_mf_hi_d),
    .is_mf_lo_d(is_mf_lo_d), .has_div_d(has_div_d),
    .valid_e(b_valid_e), .reg_write_e(b_reg_write_e), .mem_to_reg_e(b_mem_to_reg_e),
    .mem_write_e(b_mem_write_e), .alu_src_e(b_alu_src_e), .reg_dest_e(b_reg_dest_e),
    .syscall_e(b_syscall_e), .is_byte_e(b_is_byte_e), .link_reg_e(b_link_reg_e),
    .alu_op_e(b_alu_op_e), .shamt_e(b_shamt_e), .is_mf_hi_e(b_is_mf_hi_e),
    .is_mf_lo_e(b_is_mf_lo_e), .has_div_e(b_has_div_e), .stall_d(b_stall_d),
    .div_busy(b_div_busy), .div_done(b_div_done)
  );

  // Inputs change 1ns after the rising edge; checks run a further 1ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_d();
    valid_d = 0; reg_write_d = 0; mem_to_reg_d = 0; mem_write_d = 0; alu_src_d = 0;
    reg_dest_d = 0; syscall_d = 0; is_byte_d = 0; link_reg_d = 0;
    alu_op_d = 4'h0; shamt_d = 5'd0; is_mf_hi_d = 0; is_mf_lo_d = 0; has_div_d = 0;
  endtask

  task automatic set_hilo(input logic mf_hi, input logic mf_lo, input logic div);
    clear_d();
    valid_d = 1; is_mf_hi_d = mf_hi; is_mf_lo_d = mf_lo; has_div_d = div;
  endtask

  task automatic test_reset();
    reset_n = 0; stall_e = 1; flush_e = 1; valid_d = 1;
    reg_write_d = 1; mem_to_reg_d = 1; mem_write_d = 1; alu_src_d = 1; reg_dest_d = 1;
    syscall_d = 1; is_byte_d = 1; link_reg_d = 1; alu_op_d = 4'hF; shamt_d = 5'h1F;
    is_mf_hi_d = 1; is_mf_lo_d = 1; has_div_d = 1;
    tick(); tick(); #1;
    checks++;
    if (a_all !== 23'h0) begin
      errors++; $display("FAIL reset_a_state got %h want 0", a_all);
    end
    checks++;
    if (b_all !== 23'h0) begin
      errors++; $display("FAIL reset_b_state got %h want 0", b_all);
    end
    checks++;
    if (a_stall_d !== 1'b1) begin
      errors++; $display("FAIL reset_stall_follows_e got %b want 1", a_stall_d);
    end
    stall_e = 0; #1;
    checks++;
    if (a_stall_d !== 1'b0) begin
      errors++; $display("FAIL reset_stall_low got %b want 0", a_stall_d);
    end
    tick();
    reset_n = 1; flush_e = 0; clear_d(); valid_d = 1; reg_write_d = 1;
    tick(); #1;
    checks++;
    if ({a_valid_e, a_reg_write_e, a_div_busy} !== 3'b110) begin
      errors++; $display("FAIL reset_release_capture got %b want 110",
                         {a_valid_e, a_reg_write_e, a_div_busy});
    end
  endtask

  task automatic test_pass_through();
    clear_d(); valid_d = 1; reg_write_d = 1; alu_src_d = 1; alu_op_d = 4'h2; shamt_d = 5'd3;
    tick(); #1;
    checks++;
    if ({a_valid_e, a_reg_write_e, a_mem_to_reg_e, a_mem_write_e, a_alu_src_e, a_reg_dest_e,
         a_syscall_e, a_is_byte_e, a_link_reg_e, a_alu_op_e, a_shamt_e}
        !== {9'b110010000, 4'h2, 5'd3}) begin
      errors++; $display("FAIL pass_basic got %b %h %0d", a_valid_e, a_alu_op_e, a_shamt_e);
    end
    clear_d(); valid_d = 1; mem_to_reg_d = 1; mem_write_d = 1; reg_dest_d = 1;
    syscall_d = 1; is_byte_d = 1; link_reg_d = 1; alu_op_d = 4'hC; shamt_d = 5'd31;
    tick(); #1;
    checks++;
    if ({a_valid_e, a_reg_write_e, a_mem_to_reg_e, a_mem_write_e, a_alu_src_e, a_reg_dest_e,
         a_syscall_e, a_is_byte_e, a_link_reg_e, a_alu_op_e, a_shamt_e}
        !== {9'b101101111, 4'hC, 5'd31}) begin
      errors++; $display("FAIL pass_flags got %b %h %0d", a_valid_e, a_alu_op_e, a_shamt_e);
    end
    clear_d(); reg_write_d = 1; alu_op_d = 4'h9;
    tick(); #1;
    checks++;
    if ({a_valid_e, a_reg_write_e, a_alu_op_e} !== 6'b0) begin
      errors++; $display("FAIL pass_bubble got %b want 000000",
                         {a_valid_e, a_reg_write_e, a_alu_op_e});
    end
  endtask

  task automatic test_div_mflo();
    set_hilo(0, 0, 1);
    tick();
    set_hilo(0, 1, 0); #1;
    checks++;
    if ({a_valid_e, a_has_div_e, a_div_busy, a_stall_d, a_div_done} !== 5'b11110) begin
      errors++; $display("FAIL div_issue got %b want 11110",
                         {a_valid_e, a_has_div_e, a_div_busy, a_stall_d, a_div_done});
    end
    for (int k = 2; k <= 4; k++) begin
      tick(); #1;
      checks++;
      if ({a_stall_d, a_valid_e, a_div_busy, a_div_done} !== 4'b1010) begin
        errors++; $display("FAIL div_wait_%0d got %b want 1010", k,
                           {a_stall_d, a_valid_e, a_div_busy, a_div_done});
      end
    end
    tick(); #1;
    checks++;
    if ({a_stall_d, a_valid_e, a_div_busy, a_div_done} !== 4'b0001) begin
      errors++; $display("FAIL div_done_cycle got %b want 0001",
                         {a_stall_d, a_valid_e, a_div_busy, a_div_done});
    end
    tick(); #1;
    checks++;
    if ({a_valid_e, a_is_mf_lo_e, a_div_done} !== 3'b110) begin
      errors++; $display("FAIL mflo_enters_e got %b want 110",
                         {a_valid_e, a_is_mf_lo_e, a_div_done});
    end
    clear_d(); tick();
  endtask

  task automatic test_independent_op();
    set_hilo(0, 0, 1);
    tick();
    clear_d(); valid_d = 1; reg_write_d = 1; alu_src_d = 1; alu_op_d = 4'h1; #1;
    checks++;
    if (a_stall_d !== 1'b0) begin
      errors++; $display("FAIL indep_no_stall got %b want 0", a_stall_d);
    end
    tick(); #1;
    checks++;
    if ({a_valid_e, a_alu_src_e, a_alu_op_e, a_has_div_e, a_div_busy} !== 8'b11_0001_01) begin
      errors++; $display("FAIL indep_in_e got %b want 11000101",
                         {a_valid_e, a_alu_src_e, a_alu_op_e, a_has_div_e, a_div_busy});
    end
    clear_d();
    for (int k = 0; k < 5; k++) tick();
  endtask

  task automatic test_stall_flush();
    clear_d(); valid_d = 1; reg_write_d = 1; mem_write_d = 1; alu_op_d = 4'h5;
    tick();
    stall_e = 1; alu_op_d = 4'h7; mem_write_d = 0; #1;
    checks++;
    if (a_stall_d !== 1'b1) begin
      errors++; $display("FAIL stall_e_stall_d got %b want 1", a_stall_d);
    end
    tick(); #1;
    checks++;
    if ({a_valid_e, a_mem_write_e, a_alu_op_e} !== 6'b11_0101) begin
      errors++; $display("FAIL stall_hold got %b want 110101",
                         {a_valid_e, a_mem_write_e, a_alu_op_e});
    end
    flush_e = 1;
    tick(); #1;
    checks++;
    if ({a_valid_e, a_reg_write_e, a_alu_op_e} !== 6'b0) begin
      errors++; $display("FAIL flush_over_stall got %b want 000000",
                         {a_valid_e, a_reg_write_e, a_alu_op_e});
    end
    stall_e = 0; set_hilo(0, 0, 1);
    tick(); #1;
    checks++;
    if ({a_valid_e, a_div_busy} !== 2'b00) begin
      errors++; $display("FAIL flushed_div_no_issue got %b want 00", {a_valid_e, a_div_busy});
    end
    flush_e = 0; stall_e = 1;
    tick(); #1;
    checks++;
    if ({a_div_busy, a_div_done} !== 2'b00) begin
      errors++; $display("FAIL stalled_div_no_issue got %b want 00", {a_div_busy, a_div_done});
    end
    stall_e = 0; clear_d(); tick();
  endtask

  task automatic test_reset_mid_div();
    reset_n = 0; clear_d(); tick();
    reset_n = 1;
    set_hilo(0, 0, 1);
    tick();
    set_hilo(1, 0, 0); #1;
    checks++;
    if ({b_div_busy, b_stall_d, b_has_div_e} !== 3'b111) begin
      errors++; $display("FAIL b_div_issue got %b want 111", {b_div_busy, b_stall_d, b_has_div_e});
    end
    for (int k = 0; k < 3; k++) tick();
    #1;
    checks++;
    if ({b_stall_d, b_valid_e, b_div_busy} !== 3'b101) begin
      errors++; $display("FAIL b_cnt5_stalled got %b want 101", {b_stall_d, b_valid_e, b_div_busy});
    end
    reset_n = 0;
    tick(); #1;
    checks++;
    if ({b_div_busy, b_div_done, b_valid_e, b_stall_d} !== 4'b0000) begin
      errors++; $display("FAIL b_reset_abandon got %b want 0000",
                         {b_div_busy, b_div_done, b_valid_e, b_stall_d});
    end
    reset_n = 1;
    tick(); #1;
    checks++;
    if ({b_valid_e, b_is_mf_hi_e, b_div_busy} !== 3'b110) begin
      errors++; $display("FAIL b_mfhi_after_reset got %b want 110",
                         {b_valid_e, b_is_mf_hi_e, b_div_busy});
    end
    clear_d();
    for (int k = 0; k < 8; k++) begin
      tick(); #1;
      checks++;
      if ({b_div_busy, b_div_done} !== 2'b00) begin
        errors++; $display("FAIL b_no_stale_done_%0d got %b want 00", k, {b_div_busy, b_div_done});
      end
    end
  endtask

  initial begin
    reset_n = 0; stall_e = 0; flush_e = 0;
    clear_d();
    #1;
    test_reset();
    test_pass_through();
    test_div_mflo();
    test_independent_op();
    test_stall_flush();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_pipe_reg.md
Name: control_pipe_reg

Overview:
- Registered decode-to-execute control boundary for the pipelined MIPS core.
- Captures the D-stage control bundle into E-stage registers. Supports hold on downstream stall and bubble insertion on flush.
- Tracks an in-flight multi-cycle DIV with a latency counter. Stalls D when MFHI, MFLO or DIV would read or overwrite HI/LO before the divide completes.
- Sits between the control unit outputs and the execute stage. The hazard unit consumes stall_d.

Parameters:
- ALU_OP_W, 4, width of alu_op_d / alu_op_e.
- SHAMT_W, 5, width of shamt_d / shamt_e.
- DIV_LATENCY, 32, cycles from DIV entering E until HI/LO are valid. Must be ≥1; elaboration error if 0.
- CNT_W, $clog2(DIV_LATENCY+1), width of the divide counter (derived; do not override).

Ports:
- clock in 1: single clock; all state updates on the rising edge.
- reset_n in 1: synchronous, active-low reset.
- stall_e in 1: downstream stall; hold the E registers.
- flush_e in 1: load a bubble into E.
- valid_d in 1: the D-stage bundle holds a real instruction.
- reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dest_d, syscall_d, is_byte_d, link_reg_d in 1 each: D-stage control flags.
- alu_op_d in ALU_OP_W: ALU operation.
- shamt_d in SHAMT_W: shift amount.
- is_mf_hi_d, is_mf_lo_d, has_div_d in 1 each: HI/LO class flags.
- valid_e out 1: E holds a real instruction.
- reg_write_e … link_reg_e, alu_op_e, shamt_e, is_mf_hi_e, is_mf_lo_e, has_div_e out (matching widths): registered copies of the D-stage inputs.
- stall_d out 1: hold the fetch and decode stages.
- div_busy out 1: a divide is in flight.
- div_done out 1: one-cycle pulse in the first cycle HI/LO are valid.

Behaviour:
- Reset: when reset_n=0 at the edge:
  - All *_e outputs, valid_e, the counter and div_done become 0.
  - div_busy and stall_d are combinational from state and read 0 while stall_e=0.
  - Reset mid-divide abandons the divide; nothing is remembered.
- hilo_hazard (combinational) = valid_d & div_busy & (is_mf_hi_d | is_mf_lo_d | has_div_d).
- stall_d (combinational) = hilo_hazard | stall_e.
- E register update, in priority order:
  1. flush_e=1: bubble (all *_e=0, valid_e=0). flush_e wins over stall_e.
  2. stall_e=1: hold all *_e and valid_e.
  3. hilo_hazard=1 or valid_d=0: bubble.
  4. Otherwise: *_e <= *_d and valid_e <= 1.
- Divide counter:
  - issue = case 4 taken with has_div_d=1. On issue, cnt <= DIV_LATENCY.
  - Else if cnt != 0, cnt <= cnt-1. The divider runs independently, so cnt decrements regardless of stall_e and flush_e.
  - div_busy = (cnt != 0).
  - div_done is registered: div_done <= (cnt==1) & ~issue.
- Issue while busy is impossible because hilo_hazard blocks a D-stage DIV.
- A flushed or stalled DIV never issues and never loads the counter.
- Flushing E after a DIV has issued does not cancel the counter: HI/LO are still written.
- Non-HI/LO instructions pass freely while div_busy=1.
- Latency: 1 cycle from D to E. A MFHI/MFLO immediately following a DIV reaches E DIV_LATENCY+1 cycles after the DIV does.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with all inputs driven to 1 -> every output 0 (stall_d follows stall_e only). Release -> normal capture on the next edge.
- Pass-through: valid_d=1, reg_write_d=1, alu_src_d=1, alu_op_d=4'h2, shamt_d=5'd3 -> next cycle valid_e=1 with identical *_e values. valid_d=0 -> bubble the following cycle.
- DIV→MFLO, DIV_LATENCY=4: DIV in D at cycle t, MFLO in D from cycle t+1 ->
  - E=DIV at t+1; cnt=4,3,2,1 over cycles t+1..t+4.
  - stall_d=1 for exactly cycles t+1..t+4, with bubbles in E.
  - div_done=1 only in cycle t+5; MFLO valid in E at cycle t+6.
- Independent op during divide: ADDIU in D at t+1 after a DIV -> no stall. E=ADDIU at t+2 and div_busy stays 1.
- Stall/flush: stall_e=1 with a valid op in E -> E held and stall_d=1. stall_e=1 and flush_e=1 together -> valid_e=0 next cycle. A DIV in D during flush_e -> cnt stays 0.
- Reset mid-divide: DIV_LATENCY=8, assert reset_n=0 at cnt=5 with MFHI stalled in D -> next cycle div_busy=0 and div_done=0. After release, MFHI enters E on the following edge.
